// File: rtl/wb_pkg.sv
// wb_pkg: shared types and defaults for the Wishbone master bridge.
//   wb_state_t     - bridge FSM state encoding
//   WB_ADDR_W      - default Wishbone address width
//   WB_DATA_W      - default Wishbone data width
//   WB_TIMEOUT_DEF - default watchdog limit in cycles (0 disables it)
//   wb_ctr_w()     - watchdog counter width for a given limit
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam int WB_ADDR_W      = 32;
    localparam int WB_DATA_W      = 32;
    localparam int WB_TIMEOUT_DEF = 16;

    // $clog2(t+1) bits hold 0..t; a limit of 0 still needs a legal width.
    function automatic int wb_ctr_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: watchdog for one Wishbone transfer.
//   clk, reset - clock, async active-high reset
//   clear      - hold the count at 0 (bridge idle)
//   enable     - count one cycle of an unacknowledged strobe
//   expired    - count has reached TIMEOUT-1: this edge is the last
//                one the transfer may wait on; tied 0 when TIMEOUT=0
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = &{1'b0, clk, reset, clear, enable};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int            CW   = wb_ctr_w(TIMEOUT);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            // Stops at LAST rather than wrapping, so a stuck enable keeps
            // expired asserted instead of cycling back to 0.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt <= '0;
                else if (clear)
                    cnt <= '0;
                else if (enable && cnt != LAST)
                    cnt <= cnt + 1'b1;
            end

            assign expired = (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: Wishbone classic single-transfer master for the core's
// load/store/fetch port.
//   core_req/we/sel/addr/wdata - one-shot request, sampled only when idle
//   core_rdata                 - read data, held until the next completion
//   core_done / core_err       - one-cycle completion / timeout pulses
//   core_busy                  - high while a transfer is in flight
//   wb_cyc/stb/we/adr/dat_o    - registered Wishbone master outputs
//   wb_core_select             - registered core identifier
//   wb_dat_i / wb_ack          - slave read data / acknowledge
// Every output is a flop; nothing on core_* or wb_ack reaches an output
// combinationally.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_sel,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_err,
    output logic              core_busy,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic              wb_core_select,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack
);

    wb_state_t state;
    logic      wdog_clear;
    logic      wdog_en;
    logic      expired;

    assign wdog_clear = (state == IDLE);
    assign wdog_en    = (state == BUS);

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (wdog_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            core_rdata     <= '0;
            core_done      <= 1'b0;
            core_err       <= 1'b0;
            core_busy      <= 1'b0;
            wb_cyc         <= 1'b0;
            wb_stb         <= 1'b0;
            wb_we          <= 1'b0;
            wb_core_select <= 1'b0;
            wb_adr         <= '0;
            wb_dat_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        wb_adr         <= core_addr;
                        wb_we          <= core_we;
                        // Reads never drive stale write data onto the bus.
                        wb_dat_o       <= core_we ? core_wdata : '0;
                        wb_core_select <= core_sel;
                        wb_cyc         <= 1'b1;
                        wb_stb         <= 1'b1;
                        core_busy      <= 1'b1;
                        state          <= BUS;
                    end
                end
                BUS: begin
                    // Ack is tested first so an ack on the last allowed
                    // cycle completes normally instead of timing out.
                    if (wb_ack) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        if (!wb_we)
                            core_rdata <= wb_dat_i;
                        core_done <= 1'b1;
                        state     <= DONE;
                    end else if (expired) begin
                        wb_cyc     <= 1'b0;
                        wb_stb     <= 1'b0;
                        core_rdata <= '0;
                        core_done  <= 1'b1;
                        core_err   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Requests arriving here are dropped, not queued.
                    core_done <= 1'b0;
                    core_err  <= 1'b0;
                    core_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge: directed bench for wb_master_bridge with a small
// registered-ack memory slave (16 words, programmable wait states).
module tb_wb_master_bridge;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_sel;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_done, core_err, core_busy;
    logic        wb_cyc, wb_stb, wb_we, wb_core_select, wb_ack;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

    // slave model
    logic        slv_ack, slv_en, stray_ack;
    int          slv_dly, wait_cnt;
    logic [31:0] mem [16];
    logic [31:0] slv_rd;

    int errs = 0, checks = 0;

    // per-transfer observations
    int          m_cyc, m_done, m_errn, m_busy_bad, m_stb_bad, m_unstable;
    logic [31:0] m_rd, m_adr, m_dat;
    logic        m_err, m_we, m_sel;

    logic [31:0] ref_mem [10];

    assign wb_ack   = slv_ack | stray_ack;
    assign wb_dat_i = slv_rd;

    always #5 clk = ~clk;

    wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_sel(core_sel),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_done(core_done), .core_err(core_err),
        .core_busy(core_busy),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_core_select(wb_core_select), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
    );

    // Registered ack after slv_dly extra cycles of strobe; ack=1 with
    // slv_dly=0 lands in the second strobe cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            slv_ack  <= 1'b0;
            wait_cnt <= 0;
            slv_rd   <= '0;
        end else begin
            slv_ack <= 1'b0;
            if (wb_cyc && wb_stb && !slv_ack && slv_en) begin
                if (wait_cnt >= slv_dly) begin
                    slv_ack  <= 1'b1;
                    wait_cnt <= 0;
                    if (wb_we) mem[wb_adr[3:0]] <= wb_dat_o;
                    else       slv_rd <= mem[wb_adr[3:0]];
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else if (!wb_cyc) begin
                wait_cnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request pulse, then watch until done plus a 4-cycle tail.
    // poke re-raises core_req (different address) while the bus is busy.
    task automatic xfer(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic sel, input bit poke);
        int n, tail;
        bit seen;
        n = 0; tail = 0; seen = 0;
        m_cyc = 0; m_done = 0; m_errn = 0; m_busy_bad = 0; m_stb_bad = 0;
        m_unstable = 0; m_rd = '0; m_err = 1'b0;
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd; core_sel = sel;
        while (n < 200 && tail < 4) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                core_req = 1'b0;
                m_adr = wb_adr; m_we = wb_we; m_dat = wb_dat_o; m_sel = wb_core_select;
            end
            if (poke && n == 2) begin core_req = 1'b1; core_addr = addr + 1; end
            if (poke && n == 3) core_req = 1'b0;
            if (wb_cyc) begin
                m_cyc++;
                if (wb_adr != m_adr || wb_dat_o != m_dat || wb_we != m_we) m_unstable++;
            end
            if (wb_stb != wb_cyc) m_stb_bad++;
            if (core_err) m_errn++;
            if (seen) tail++;
            if (!seen && !core_busy) m_busy_bad++;
            if (core_done) begin
                seen = 1; m_done++; m_rd = core_rdata; m_err = core_err;
            end
        end
        if (!seen) chk("done_within_budget", 64'd0, 64'd1);
    endtask

    initial begin
        int ra, busy_tot, done_tot, nd;
        reset = 1'b1; core_req = 0; core_we = 0; core_sel = 0;
        core_addr = '0; core_wdata = '0;
        slv_en = 1'b1; slv_dly = 0; stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_flags", {core_done, core_err, core_busy, wb_cyc, wb_stb, wb_we, wb_core_select}, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat_o", wb_dat_o, 0);
        reset = 1'b0;

        // write 0x1234 to addr 3, zero-wait slave
        xfer(1'b1, 32'd3, 32'h1234, 1'b1, 0);
        chk("wr_cyc_cycles", m_cyc, 2);
        chk("wr_adr", m_adr, 3);
        chk("wr_we", m_we, 1);
        chk("wr_dat_o", m_dat, 32'h1234);
        chk("wr_sel", m_sel, 1);
        chk("wr_done_pulses", m_done, 1);
        chk("wr_err", m_err, 0);
        chk("wr_stb_eq_cyc", m_stb_bad, 0);

        // read it back; wdata must not leak onto dat_o
        xfer(1'b0, 32'd3, 32'hDEADBEEF, 1'b0, 0);
        chk("rd_rdata", m_rd, 32'h1234);
        chk("rd_dat_o", m_dat, 0);
        chk("rd_we", m_we, 0);
        chk("rd_cyc_cycles", m_cyc, 2);

        // slave never acks
        slv_en = 1'b0;
        xfer(1'b0, 32'd3, 32'h0, 1'b0, 0);
        chk("to_cyc_cycles", m_cyc, 16);
        chk("to_done_pulses", m_done, 1);
        chk("to_err_with_done", m_err, 1);
        chk("to_err_pulses", m_errn, 1);
        chk("to_rdata", m_rd, 0);
        slv_en = 1'b1;

        // ack in the 16th strobe cycle beats the watchdog
        slv_dly = 14;
        xfer(1'b0, 32'd3, 32'h0, 1'b0, 0);
        chk("ack16_cyc_cycles", m_cyc, 16);
        chk("ack16_err", m_err, 0);
        chk("ack16_err_pulses", m_errn, 0);
        chk("ack16_rdata", m_rd, 32'h1234);
        slv_dly = 0;

        // stray ack while idle
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        chk("stray_idle", {core_done, core_err, core_busy, wb_cyc}, 0);
        @(negedge clk);
        chk("stray_idle_after", {core_done, wb_cyc}, 0);

        // second request during BUS is dropped
        slv_dly = 2;
        xfer(1'b1, 32'd5, 32'hA5A5, 1'b0, 1);
        chk("poke_cyc_cycles", m_cyc, 4);
        chk("poke_done_pulses", m_done, 1);
        chk("poke_adr", m_adr, 5);
        chk("poke_stable", m_unstable, 0);
        slv_dly = 0;

        // reset between edges during BUS
        slv_en = 1'b0;
        @(negedge clk); core_req = 1'b1; core_we = 1'b0; core_addr = 32'd7;
        @(negedge clk); core_req = 1'b0;
        chk("rst_mid_cyc_before", wb_cyc, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_cyc", wb_cyc, 0);
        chk("rst_mid_stb", wb_stb, 0);
        chk("rst_mid_busy", core_busy, 0);
        nd = 0;
        repeat (2) begin @(negedge clk); if (core_done || core_err) nd++; end
        reset = 1'b0;
        slv_en = 1'b1;
        repeat (3) begin @(negedge clk); if (core_done || core_err || wb_cyc) nd++; end
        chk("rst_mid_no_done", nd, 0);

        // normal read after reset
        xfer(1'b0, 32'd3, 32'h0, 1'b0, 0);
        chk("post_rst_rdata", m_rd, 32'h1234);
        chk("post_rst_done", m_done, 1);
        chk("post_rst_err", m_err, 0);

        // ten writes, then read one back
        busy_tot = 0; done_tot = 0;
        for (int i = 0; i < 10; i++) begin
            ref_mem[i] = $urandom;
            xfer(1'b1, i, ref_mem[i], i[0], 0);
            busy_tot += m_busy_bad;
            done_tot += m_done;
        end
        ra = $urandom_range(9);
        xfer(1'b0, ra, 32'h0, 1'b0, 0);
        busy_tot += m_busy_bad;
        chk("burst_rdata", m_rd, ref_mem[ra]);
        chk("burst_done_count", done_tot, 10);
        chk("burst_busy_low", busy_tot, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic single-transfer master between the multicycle core's load/store/fetch port and the memory controller slave (mem_ctrl_top).
- Converts a one-shot core request into a registered cyc/stb/we/adr/dat cycle and waits for ack.
- Returns read data with a one-cycle done pulse.
- A watchdog aborts transfers the slave never acknowledges, so the core cannot hang.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width.
- TIMEOUT, 16, maximum cycles cyc/stb stay high without ack; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  transfer request; sampled only in IDLE.
- core_we  in  1  1 = write, 0 = read.
- core_sel  in  1  core identifier, forwarded to wb_core_select.
- core_addr  in  ADDR_W  transfer address.
- core_wdata  in  DATA_W  write data.
- core_rdata  out  DATA_W  read data; valid while core_done=1, held until the next completion.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  one-cycle pulse, coincident with core_done, on timeout.
- core_busy  out  1  high whenever state != IDLE.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe; always equal to wb_cyc.
- wb_we  out  1  write enable.
- wb_core_select  out  1  registered core_sel.
- wb_adr  out  ADDR_W  address.
- wb_dat_o  out  DATA_W  write data to slave.
- wb_dat_i  in  DATA_W  read data from slave.
- wb_ack  in  1  slave acknowledge.

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0. Every output is 0: core_rdata, core_done, core_err, core_busy, wb_cyc, wb_stb, wb_we, wb_core_select, wb_adr, wb_dat_o.
- Reset mid-transfer: cyc/stb drop at once, no done/err pulse, latched request discarded.
- All outputs are registered; no combinational path from core_* or wb_ack to any output.
- States: IDLE, BUS, DONE.
- IDLE:
  - On an edge with core_req=1, latch addr/we/wdata/sel into wb_adr/wb_we/wb_dat_o/wb_core_select, set wb_cyc=wb_stb=1, counter=0, go BUS.
  - wb_dat_o is latched as 0 for reads.
- BUS:
  - wb_adr, wb_we, wb_dat_o, wb_core_select are held stable.
  - On an edge with wb_ack=1: drop cyc/stb, load core_rdata (reads: wb_dat_i; writes: unchanged), core_done=1, go DONE.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: drop cyc/stb, core_rdata=0, core_done=1, core_err=1, go DONE.
  - Otherwise counter increments.
  - Ack in the final timeout cycle wins; no error is raised.
- DONE: lasts one cycle. core_done/core_err clear on exit; go IDLE.
- Latency:
  - core_req sampled at edge k, so cyc visible after k.
  - Zero-wait ack sampled at edge k+1, so core_done is high in the cycle after k+1.
  - Minimum request-to-done is 2 edges. Minimum back-to-back issue interval is 3 cycles.
- Handshake rules:
  - core_req while BUS/DONE is ignored, not queued.
  - The core may hold core_req level but must drop it at the edge where it samples core_done=1; otherwise the request reissues.
- wb_ack while not in BUS is ignored.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Package wb_pkg:
  - state enum wb_state_t {IDLE, BUS, DONE};
  - default WB_ADDR_W / WB_DATA_W constants;
  - WB_TIMEOUT_DEF = 16.
- One natural sub-module, wb_timeout_ctr:
  - inputs clear/enable;
  - output expired;
  - parameter TIMEOUT, with TIMEOUT=0 tying expired to 0.
- FSM and datapath stay in wb_master_bridge.

Test Plan:
- Write, slave acks 1 cycle after stb: core_req with we=1, addr=3, wdata=0x1234 -> cyc/stb high for exactly 2 cycles, adr=3, dat_o=0x1234, we=1; one core_done pulse; core_err=0.
- Read of addr 3 against mem_ctrl_top after the write -> core_rdata=0x1234 during core_done; dat_o=0 during the read.
- Slave never acks, TIMEOUT=16 -> cyc high exactly 16 cycles; core_done and core_err pulse together; core_rdata=0.
- Ack on the 16th cycle -> normal done, err=0.
- Second core_req during BUS and a stray ack in IDLE -> both ignored; exactly one wb cycle and one done.
- Reset asserted between edges during BUS -> wb_cyc and wb_stb fall before the next edge; no done.
- After reset deasserts, a new read completes normally.
- Ten back-to-back writes of random data to addresses 0..9, then a read of a random address 0..9 -> returned data matches the value written there; core_busy never low during any transfer.
